// File: rtl/decode_stage.sv
// Registered RV32 decode stage with a one-entry skid buffer, explicit illegal-instruction
// detection and same-cycle flush. Define DECODE_FENCE_EN to decode FENCE/FENCE.I as a bubble.
module decode_stage #(
    parameter int PC_W        = 32,
    parameter bit ZERO_IS_NOP = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [PC_W-1:0] i_pc,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [PC_W-1:0] o_pc,
    output logic [4:0]      o_rd,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [2:0]      o_funct3,
    output logic [1:0]      o_ALUOp,
    output logic            o_ALUSrc,
    output logic [2:0]      o_immSrc,
    output logic [1:0]      o_resultMSrc,
    output logic            o_resultWSrc,
    output logic            o_regWrite,
    output logic            o_memReq,
    output logic            o_memWrite,
    output logic            o_branch,
    output logic            o_jal,
    output logic            o_jalr,
    output logic            o_immPlusSrc,
    output logic            o_isLoadSigned,
    output logic            o_exception,
    output logic [3:0]      o_excCause
);

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic [2:0] imm_src;
        logic [1:0] result_m_src;
        logic       result_w_src;
        logic       reg_write;
        logic       mem_req;
        logic       mem_write;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       imm_plus_src;
        logic       is_load_signed;
        logic       exception;
        logic [3:0] exc_cause;
    } ctrl_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        ctrl_t           ctrl;
    } bundle_t;

    function automatic ctrl_t decode_instr(input logic [31:0] instr);
        ctrl_t      c;
        logic       illegal;
        logic       bubble;
        logic [2:0] f3;
        logic [11:0] imm12;
        c       = '0;
        illegal = 1'b0;
        bubble  = 1'b0;
        f3      = instr[14:12];
        imm12   = instr[31:20];
        case (instr[6:0])
            7'b0000011: begin
                c.alu_src      = 1'b1;
                c.imm_src      = 3'd1;
                c.result_w_src = 1'b1;
                c.reg_write    = 1'b1;
                c.mem_req      = 1'b1;
            end
            7'b0010011: begin
                c.alu_op    = 2'b10;
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                c.imm_src   = (f3[1:0] == 2'b01) ? 3'd2 : 3'd1;
            end
            7'b0100011: begin
                c.alu_src   = 1'b1;
                c.imm_src   = 3'd3;
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
            end
            7'b0110011: begin
                c.alu_op    = 2'b10;
                c.reg_write = 1'b1;
            end
            7'b0010111, 7'b0110111: begin
                c.imm_src      = 3'd4;
                c.result_m_src = 2'd1;
                c.reg_write    = 1'b1;
            end
            7'b1100011: begin
                c.alu_op  = 2'b01;
                c.imm_src = 3'd5;
                c.branch  = 1'b1;
            end
            7'b1100111: begin
                c.imm_src      = 3'd6;
                c.result_m_src = 2'd2;
                c.reg_write    = 1'b1;
                c.jalr         = 1'b1;
            end
            7'b1101111: begin
                c.imm_src      = 3'd7;
                c.result_m_src = 2'd2;
                c.reg_write    = 1'b1;
                c.jal          = 1'b1;
            end
            7'b1110011: begin
                c.exception    = 1'b1;
                c.result_m_src = 2'd3;
                case (f3)
                    3'b000: begin
                        if (imm12 == 12'd0) begin
                            c.exc_cause = 4'd11;
                        end else if (imm12 == 12'd1) begin
                            c.exc_cause = 4'd3;
                        end else begin
                            c.exc_cause = 4'd0;
                        end
                    end
                    3'b100:  illegal     = 1'b1;
                    default: c.reg_write = 1'b1;
                endcase
            end
`ifdef DECODE_FENCE_EN
            7'b0001111: bubble = 1'b1;
`endif
            default: illegal = 1'b1;
        endcase
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            illegal = illegal;
        end
        // The zero word fails the low-bits check, so its own rule must override it.
        if (instr == 32'd0) begin
            bubble  = ZERO_IS_NOP;
            illegal = !ZERO_IS_NOP;
        end else begin
            bubble = bubble;
        end
        if (bubble) begin
            c = '0;
        end else if (illegal) begin
            c           = '0;
            c.exception = 1'b1;
            c.exc_cause = 4'd2;
        end else begin
            c.imm_plus_src   = !instr[5];
            c.is_load_signed = !instr[14];
        end
        return c;
    endfunction

    bundle_t in_bundle_s;
    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;
    logic    main_valid_q, main_valid_d;
    logic    skid_full_q, skid_full_d;
    logic    ready_q;
    logic    accept_s;
    logic    drain_s;

    // Incoming instruction decoded into a bundle ready for capture.
    always_comb begin
        in_bundle_s        = '0;
        in_bundle_s.pc     = i_pc;
        in_bundle_s.rd     = i_instr[11:7];
        in_bundle_s.rs1    = i_instr[19:15];
        in_bundle_s.rs2    = i_instr[24:20];
        in_bundle_s.funct3 = i_instr[14:12];
        in_bundle_s.ctrl   = decode_instr(i_instr);
    end

    assign accept_s = i_valid && ready_q;
    assign drain_s  = main_valid_q && i_ready;

    // Main/skid next state; flush dominates, skid refills main before new input.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_full_d  = skid_full_q;
        if (i_flush) begin
            main_valid_d = 1'b0;
            skid_full_d  = 1'b0;
        end else if (!main_valid_q || drain_s) begin
            if (skid_full_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_full_d  = 1'b0;
            end else if (accept_s) begin
                main_d       = in_bundle_s;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept_s) begin
            skid_d      = in_bundle_s;
            skid_full_d = 1'b1;
        end else begin
            skid_full_d = skid_full_q;
        end
    end

    // State registers; ready is kept as its own flop so it never depends on i_ready.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_full_q  <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_full_q  <= skid_full_d;
            ready_q      <= !skid_full_d;
        end
    end

    assign o_ready        = ready_q;
    assign o_valid        = main_valid_q;
    assign o_pc           = main_q.pc;
    assign o_rd           = main_q.rd;
    assign o_rs1          = main_q.rs1;
    assign o_rs2          = main_q.rs2;
    assign o_funct3       = main_q.funct3;
    assign o_ALUOp        = main_q.ctrl.alu_op;
    assign o_ALUSrc       = main_q.ctrl.alu_src;
    assign o_immSrc       = main_q.ctrl.imm_src;
    assign o_resultMSrc   = main_q.ctrl.result_m_src;
    assign o_resultWSrc   = main_q.ctrl.result_w_src;
    assign o_regWrite     = main_q.ctrl.reg_write;
    assign o_memReq       = main_q.ctrl.mem_req;
    assign o_memWrite     = main_q.ctrl.mem_write;
    assign o_branch       = main_q.ctrl.branch;
    assign o_jal          = main_q.ctrl.jal;
    assign o_jalr         = main_q.ctrl.jalr;
    assign o_immPlusSrc   = main_q.ctrl.imm_plus_src;
    assign o_isLoadSigned = main_q.ctrl.is_load_signed;
    assign o_exception    = main_q.ctrl.exception;
    assign o_excCause     = main_q.ctrl.exc_cause;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: decode table, skid/stall behaviour, flush and async reset.
module tb_decode_stage;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_pc;
    logic [4:0]  o_rd, o_rs1, o_rs2;
    logic [2:0]  o_funct3;
    logic [1:0]  o_ALUOp;
    logic        o_ALUSrc;
    logic [2:0]  o_immSrc;
    logic [1:0]  o_resultMSrc;
    logic        o_resultWSrc, o_regWrite, o_memReq, o_memWrite, o_branch, o_jal, o_jalr;
    logic        o_immPlusSrc, o_isLoadSigned, o_exception;
    logic [3:0]  o_excCause;

    int n_vec;
    int n_bad;

    logic [21:0] ctl_s;
    assign ctl_s = {o_ALUOp, o_ALUSrc, o_immSrc, o_resultMSrc, o_resultWSrc, o_regWrite,
                    o_memReq, o_memWrite, o_branch, o_jal, o_jalr, o_immPlusSrc,
                    o_isLoadSigned, o_exception, o_excCause};

    decode_stage #(.PC_W(32), .ZERO_IS_NOP(1'b1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid),
        .i_ready(i_ready), .o_pc(o_pc), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2),
        .o_funct3(o_funct3), .o_ALUOp(o_ALUOp), .o_ALUSrc(o_ALUSrc), .o_immSrc(o_immSrc),
        .o_resultMSrc(o_resultMSrc), .o_resultWSrc(o_resultWSrc), .o_regWrite(o_regWrite),
        .o_memReq(o_memReq), .o_memWrite(o_memWrite), .o_branch(o_branch), .o_jal(o_jal),
        .o_jalr(o_jalr), .o_immPlusSrc(o_immPlusSrc), .o_isLoadSigned(o_isLoadSigned),
        .o_exception(o_exception), .o_excCause(o_excCause)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Expected control word, fields in the same order as ctl_s.
    function automatic logic [21:0] mk(input int aop, input int asrc, input int isrc, input int rm,
                                       input int rw, input int regw, input int mreq, input int mw,
                                       input int br, input int jl, input int jr, input int ips,
                                       input int ils, input int exc, input int cause);
        return {aop[1:0], asrc[0], isrc[2:0], rm[1:0], rw[0], regw[0], mreq[0], mw[0],
                br[0], jl[0], jr[0], ips[0], ils[0], exc[0], cause[3:0]};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    logic [31:0] v_instr[18];
    logic [21:0] v_ctl[18];

    initial begin
        n_vec = 0;
        n_bad = 0;
        v_instr[0]  = 32'h00100073; v_ctl[0]  = mk(0,0,0,3,0,0,0,0,0,0,0,0,1,1,3);
        v_instr[1]  = 32'h30200073; v_ctl[1]  = mk(0,0,0,3,0,0,0,0,0,0,0,0,1,1,0);
        v_instr[2]  = 32'h000020F3; v_ctl[2]  = mk(0,0,0,3,0,1,0,0,0,0,0,0,1,1,0);
        v_instr[3]  = 32'h000070F3; v_ctl[3]  = mk(0,0,0,3,0,1,0,0,0,0,0,0,0,1,0);
        v_instr[4]  = 32'h00004073; v_ctl[4]  = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1,2);
        v_instr[5]  = 32'h0020A023; v_ctl[5]  = mk(0,1,3,0,0,0,1,1,0,0,0,0,1,0,0);
        v_instr[6]  = 32'h00000063; v_ctl[6]  = mk(1,0,5,0,0,0,0,0,1,0,0,0,1,0,0);
        v_instr[7]  = 32'h0000006F; v_ctl[7]  = mk(0,0,7,2,0,1,0,0,0,1,0,0,1,0,0);
        v_instr[8]  = 32'h00008067; v_ctl[8]  = mk(0,0,6,2,0,1,0,0,0,0,1,0,1,0,0);
        v_instr[9]  = 32'h000000B7; v_ctl[9]  = mk(0,0,4,1,0,1,0,0,0,0,0,0,1,0,0);
        v_instr[10] = 32'h00000097; v_ctl[10] = mk(0,0,4,1,0,1,0,0,0,0,0,1,1,0,0);
        v_instr[11] = 32'h00109093; v_ctl[11] = mk(2,1,2,0,0,1,0,0,0,0,0,1,1,0,0);
        v_instr[12] = 32'h002081B3; v_ctl[12] = mk(2,0,0,0,0,1,0,0,0,0,0,0,1,0,0);
        v_instr[13] = 32'h00000000; v_ctl[13] = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
`ifdef DECODE_FENCE_EN
        v_instr[14] = 32'h0000000F; v_ctl[14] = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
`else
        v_instr[14] = 32'h0000000F; v_ctl[14] = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1,2);
`endif
        v_instr[15] = 32'h00000002; v_ctl[15] = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1,2);
        v_instr[16] = 32'h0000007F; v_ctl[16] = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1,2);
        v_instr[17] = 32'h00500093; v_ctl[17] = mk(2,1,1,0,0,1,0,0,0,0,0,1,1,0,0);

        // Reset held with a valid instruction presented.
        i_rst_n = 1'b0;
        i_valid = 1'b1;
        i_instr = 32'h00500093;
        i_pc    = 32'h00000100;
        i_flush = 1'b0;
        i_ready = 1'b1;
        repeat (3) step();
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_ctl", 64'(ctl_s), 64'd0);
        chk("rst_pc", 64'(o_pc), 64'd0);
        i_rst_n = 1'b1;
        step();
        chk("addi_valid", 64'(o_valid), 64'd1);
        chk("addi_ctl", 64'(ctl_s), 64'(mk(2,1,1,0,0,1,0,0,0,0,0,1,1,0,0)));
        chk("addi_rd", 64'(o_rd), 64'd1);
        chk("addi_rs1", 64'(o_rs1), 64'd0);
        chk("addi_pc", 64'(o_pc), 64'h100);

        // Full-rate stream: lw then ecall.
        i_instr = 32'h0000A103;
        i_pc    = 32'h00000104;
        step();
        chk("lw_ctl", 64'(ctl_s), 64'(mk(0,1,1,0,1,1,1,0,0,0,0,1,1,0,0)));
        chk("lw_fields", 64'({o_rd, o_rs1, o_rs2, o_funct3}), 64'({5'd2, 5'd1, 5'd0, 3'd2}));
        chk("lw_ready", 64'(o_ready), 64'd1);
        i_instr = 32'h00000073;
        i_pc    = 32'h00000108;
        step();
        chk("ecall_ctl", 64'(ctl_s), 64'(mk(0,0,0,3,0,0,0,0,0,0,0,0,1,1,11)));
        chk("ecall_pc", 64'(o_pc), 64'h108);

        for (int i = 0; i < 18; i++) begin
            i_instr = v_instr[i];
            i_pc    = 32'h00001000 + 32'(i) * 32'd4;
            step();
            chk($sformatf("vec%0d_ctl", i), 64'(ctl_s), 64'(v_ctl[i]));
            chk($sformatf("vec%0d_valid", i), 64'(o_valid), 64'd1);
            chk($sformatf("vec%0d_pc", i), 64'(o_pc), 64'(32'h00001000 + 32'(i) * 32'd4));
            chk($sformatf("vec%0d_ready", i), 64'(o_ready), 64'd1);
        end
        i_valid = 1'b0;
        step();
        chk("drain_valid", 64'(o_valid), 64'd0);

        // Stall: three sends with i_ready low.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_instr = 32'h00500093; i_pc = 32'h0000A000;
        step();
        chk("stall_main_pc", 64'(o_pc), 64'hA000);
        chk("stall_ready1", 64'(o_ready), 64'd1);
        i_instr = 32'h0000A103; i_pc = 32'h0000A004;
        step();
        chk("stall_ready0", 64'(o_ready), 64'd0);
        chk("stall_hold_pc", 64'(o_pc), 64'hA000);
        i_instr = 32'h002081B3; i_pc = 32'h0000A008;
        repeat (2) step();
        chk("stall_hold_pc2", 64'(o_pc), 64'hA000);
        chk("stall_hold_ctl", 64'(ctl_s), 64'(mk(2,1,1,0,0,1,0,0,0,0,0,1,1,0,0)));
        chk("stall_ready_low", 64'(o_ready), 64'd0);
        i_ready = 1'b1;
        step();
        chk("rel_pc_b", 64'(o_pc), 64'hA004);
        chk("rel_ctl_b", 64'(ctl_s), 64'(mk(0,1,1,0,1,1,1,0,0,0,0,1,1,0,0)));
        chk("rel_ready", 64'(o_ready), 64'd1);
        step();
        chk("rel_pc_c", 64'(o_pc), 64'hA008);
        chk("rel_valid_c", 64'(o_valid), 64'd1);
        i_valid = 1'b0;
        step();
        chk("rel_empty", 64'(o_valid), 64'd0);

        // Flush with main and skid full plus a new valid.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_instr = 32'h00500093; i_pc = 32'h0000B000;
        step();
        i_pc = 32'h0000B004;
        step();
        i_pc    = 32'h0000B008;
        i_flush = 1'b1;
        step();
        chk("flush_valid", 64'(o_valid), 64'd0);
        chk("flush_ready", 64'(o_ready), 64'd1);
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        step();
        chk("flush_none1", 64'(o_valid), 64'd0);
        step();
        chk("flush_none2", 64'(o_valid), 64'd0);

        // Flush discards an instruction accepted in the same cycle.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_pc    = 32'h0000C000;
        step();
        i_pc    = 32'h0000C004;
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("flush_acc_valid", 64'(o_valid), 64'd0);
        chk("flush_acc_ready", 64'(o_ready), 64'd1);
        i_ready = 1'b1;
        step();
        chk("flush_acc_none", 64'(o_valid), 64'd0);

        // Asynchronous reset mid-stall with the skid full.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_pc    = 32'h0000D000;
        step();
        i_pc = 32'h0000D004;
        step();
        i_valid = 1'b0;
        chk("pre_arst_ready", 64'(o_ready), 64'd0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(o_valid), 64'd0);
        chk("arst_ready", 64'(o_ready), 64'd1);
        chk("arst_pc", 64'(o_pc), 64'd0);
        #1;
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        step();
        chk("post_arst_empty", 64'(o_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32 instruction-decode stage. It sits between the fetch buffer and the execute stage. It accepts one instruction and its PC per handshake and produces a registered control bundle one cycle later. It holds a one-entry skid buffer so it can absorb an execute-side stall without combinational ready paths. It replaces the don't-care decode of unknown opcodes with explicit illegal-instruction detection and a cause code, and supports a same-cycle pipeline flush.

## Interface
- PC_W, 32, width of the PC carried alongside the instruction
- ZERO_IS_NOP, 1, when 1 the all-zero word decodes as a bubble (no side effects, no exception); when 0 it is illegal
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage can accept; registered, equals !skid_full
- i_instr  in  32  instruction word
- i_pc  in  PC_W  instruction PC
- i_flush  in  1  discard every held and incoming instruction
- o_valid  out  1  decoded bundle valid
- i_ready  in  1  execute accepts bundle
- o_pc  out  PC_W  PC of the held instruction
- o_rd, o_rs1, o_rs2  out  5 each  instr[11:7], [19:15], [24:20]
- o_funct3  out  3  instr[14:12]
- o_ALUOp  out  2  00 add, 01 branch compare, 10 funct-decoded
- o_ALUSrc  out  1  1 selects the immediate
- o_immSrc  out  3  immediate format: 0 none, 1 I, 2 I-shift, 3 S, 4 U, 5 B, 6 I-jalr, 7 J
- o_resultMSrc  out  2  0 ALU, 1 U-imm/PC, 2 PC+4, 3 CSR
- o_resultWSrc  out  1  1 selects load data
- o_regWrite, o_memReq, o_memWrite, o_branch, o_jal, o_jalr  out  1 each
- o_immPlusSrc  out  1  !instr[5]
- o_isLoadSigned  out  1  !instr[14]
- o_exception  out  1  trap or system-op request
- o_excCause  out  4  mcause code, valid when o_exception=1

## Operation
- The decode function is combinational on i_instr. Its result plus pc/fields are captured into the output register on acceptance.
- Decode by opcode. Any field not listed below is 0.
  - 0000011 load: ALUSrc, immSrc=1, resultWSrc, regWrite, memReq.
  - 0010011 OP-IMM: ALUOp=10, ALUSrc, regWrite. immSrc=2 if funct3[1:0]=01, else 1.
  - 0100011 store: ALUSrc, immSrc=3, memReq, memWrite.
  - 0110011 OP: ALUOp=10, regWrite.
  - 0010111 / 0110111 auipc/lui: immSrc=4, resultMSrc=1, regWrite.
  - 1100011 branch: ALUOp=01, immSrc=5, branch.
  - 1100111 jalr: immSrc=6, resultMSrc=2, regWrite, jalr.
  - 1101111 jal: immSrc=7, resultMSrc=2, regWrite, jal.
  - 1110011 SYSTEM: exception=1, resultMSrc=3.
    - funct3=000, imm12=0: cause 11 (ecall).
    - funct3=000, imm12=1: cause 3 (ebreak).
    - funct3=000, other imm12: cause 0 (xRET/WFI, CSR unit resolves).
    - funct3 in {001,010,011,101,110,111}: regWrite=1, cause 0.
    - funct3=100: illegal.
- Illegal is any of: instr[1:0]≠11, an unlisted opcode, SYSTEM funct3=100, or the zero word with ZERO_IS_NOP=0. Illegal decodes with all controls 0, exception=1, cause=2.
- Bubble (zero word with ZERO_IS_NOP=1): all controls 0, exception=0. It is still presented with o_valid=1.
- Buffering uses a main register plus a one-entry skid.
  - Accept when i_valid && o_ready.
  - If the main register is empty, or is emptying this cycle (o_valid && i_ready), the accepted entry goes to main. Otherwise it goes to the skid and skid_full sets.
  - When main empties and the skid is full, the skid moves to main and skid_full clears.
- Flush: on an edge where i_flush=1, both entries are cleared. An instruction accepted in that same cycle is discarded. i_flush has priority over every other event.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N gives o_valid=1 after edge N with its bundle.
- Throughput is one instruction per cycle while i_ready=1.
- Outputs are stable while o_valid && !i_ready.
- o_ready is a register, not a combinational function of i_ready. It falls the cycle after the skid fills and rises the cycle after the skid drains.
- Reset (asynchronous, any time, including mid-transfer):
  - o_valid=0, skid empty, o_ready=1.
  - All bundle outputs are 0, including o_pc and o_excCause.
- Simultaneous accept and output drain with the skid empty means a straight pass into main, and o_ready stays 1.

## Configuration
- DECODE_FENCE_EN defined: opcode 0001111 (FENCE/FENCE.I) decodes as a bubble, with all controls 0 and exception=0.
- DECODE_FENCE_EN undefined: opcode 0001111 is illegal, with exception=1 and cause=2.

## Test plan
- Reset with i_valid=1 and i_instr=0x00500093 held: outputs are 0 and o_ready=1. After release, 0x00500093 (addi) then gives ALUOp=10, ALUSrc=1, immSrc=1, regWrite=1, rd=1, rs1=0.
- Stream 0x0000A103 (lw x2,0(x1)) then 0x00000073 (ecall) at full rate:
  - lw gives memReq=1, resultWSrc=1, isLoadSigned=1.
  - ecall gives exception=1, excCause=11.
- Hold i_ready=0 over three upstream sends:
  - The 1st is in main and the 2nd is in the skid.
  - o_ready=0 from the cycle after the skid fills. The 3rd is not accepted while o_ready=0.
  - Releasing i_ready delivers all three in order with no loss.
- Assert i_flush with main and skid full and a new i_valid: o_valid=0 next cycle, o_ready=1, and none of the three instructions appears.
- 0x0000000F: with DECODE_FENCE_EN, exception=0 and all controls are 0. Without it, exception=1 and excCause=2. 0x00000002 gives exception=1, cause=2 in both builds.
- Assert i_rst_n low mid-stall with the skid full: o_valid=0 and o_ready=1 immediately, without waiting for a clock edge.
